// File: rtl/alu_mc.sv
// Multi-cycle Hack-compatible ALU with shift-add multiply, carry/overflow flags
// and a registered result behind valid/ready handshakes on both sides.
module alu_mc #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             mul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_no;

    logic [WIDTH-1:0] w_x0;
    logic [WIDTH-1:0] w_y0;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_hack_out;
    logic             w_hack_cy;
    logic             w_hack_ov;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_mul_out;
    logic             w_mul;
    logic             w_accept;
    logic             w_last;

    function automatic logic [WIDTH-1:0] f_pre(input logic z, input logic n,
                                               input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] t;
        t = z ? '0 : v;
        return n ? ~t : t;
    endfunction

    // Operand preprocessing and single-cycle Hack datapath
    assign w_x0       = f_pre(zx, nx, x);
    assign w_y0       = f_pre(zy, ny, y);
    assign w_sum      = {1'b0, w_x0} + {1'b0, w_y0};
    assign w_r        = f ? w_sum[WIDTH-1:0] : (w_x0 & w_y0);
    assign w_hack_out = no ? ~w_r : w_r;
    assign w_hack_cy  = f & w_sum[WIDTH];
    assign w_hack_ov  = f & (w_x0[WIDTH-1] == w_y0[WIDTH-1])
                          & (w_sum[WIDTH-1] != w_x0[WIDTH-1]);

    assign w_mul     = mul & MUL_EN;
    assign w_accept  = in_valid & in_ready;
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_out = r_no ? ~w_acc_nxt : w_acc_nxt;
    // Final shift-add step also commits the result, so DONE follows it directly
    assign w_last    = (r_state == S_CALC) && (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = w_mul ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_nxt = w_mul ? S_CALC : S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
        out_valid = (r_state == S_DONE);
    end

    // Multiplier working registers; state gates their use, so no reset needed
    always_ff @(posedge clk) begin
        if (w_accept && w_mul) begin
            r_mcand  <= w_x0;
            r_mplier <= w_y0;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
            r_no     <= no;
        end else if (r_state == S_CALC) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
            zr  <= 1'b0;
            ng  <= 1'b0;
            cy  <= 1'b0;
            ov  <= 1'b0;
        end else if (w_accept && !w_mul) begin
            out <= w_hack_out;
            zr  <= ~|w_hack_out;
            ng  <= w_hack_out[WIDTH-1];
            cy  <= w_hack_cy;
            ov  <= w_hack_ov;
        end else if (w_last) begin
            out <= w_mul_out;
            zr  <= ~|w_mul_out;
            ng  <= w_mul_out[WIDTH-1];
            cy  <= 1'b0;
            ov  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a 16-bit and an 8-bit instance, directed vectors,
// expected results queued at issue and checked by per-instance monitors.
module tb_alu_mc;

    typedef struct {
        logic [15:0] out;
        logic        zr;
        logic        ng;
        logic        cy;
        logic        ov;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit instance
    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1;
    logic [15:0] x16 = '0, y16 = '0, out16;
    logic        zx16 = 0, nx16 = 0, zy16 = 0, ny16 = 0, f16 = 0, no16 = 0, mul16 = 0;
    logic        zr16, ng16, cy16, ov16;

    // 8-bit instance
    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [7:0]  x8 = '0, y8 = '0, out8;
    logic        zx8 = 0, nx8 = 0, zy8 = 0, ny8 = 0, f8 = 0, no8 = 0, mul8 = 0;
    logic        zr8, ng8, cy8, ov8;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;

    alu_mc #(.WIDTH(16), .MUL_EN(1'b1)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .x(x16), .y(y16), .zx(zx16), .nx(nx16), .zy(zy16), .ny(ny16), .f(f16), .no(no16),
        .mul(mul16), .out_valid(out_valid16), .out_ready(out_ready16), .out(out16),
        .zr(zr16), .ng(ng16), .cy(cy16), .ov(ov16)
    );

    alu_mc #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .x(x8), .y(y8), .zx(zx8), .nx(nx8), .zy(zy8), .ny(ny8), .f(f8), .no(no8),
        .mul(mul8), .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
        .zr(zr8), .ng(ng8), .cy(cy8), .ov(ov8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic issue16(input logic [15:0] ix, input logic [15:0] iy, input logic [5:0] c,
                           input logic im, input logic [15:0] eo, input logic ezr,
                           input logic eng, input logic ecy, input logic eov,
                           input int lat, input bit push);
        int   n;
        exp_t e;
        x16 = ix; y16 = iy; {zx16, nx16, zy16, ny16, f16, no16} = c; mul16 = im;
        in_valid16 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready16 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready16) begin
            checks++; errors++;
            $display("FAIL accept16: in_ready never rose, got 0 expected 1");
        end else if (push) begin
            e.out = eo; e.zr = ezr; e.ng = eng; e.cy = ecy; e.ov = eov;
            e.lat = lat; e.acc = cyc + 1;
            q16.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        x16 = 16'hDEAD; y16 = 16'hBEEF; mul16 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] ix, input logic [7:0] iy, input logic [5:0] c,
                          input logic im, input logic [7:0] eo, input logic ezr,
                          input logic eng, input logic ecy, input logic eov, input int lat);
        int   n;
        exp_t e;
        x8 = ix; y8 = iy; {zx8, nx8, zy8, ny8, f8, no8} = c; mul8 = im;
        in_valid8 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready8 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready8) begin
            checks++; errors++;
            $display("FAIL accept8: in_ready never rose, got 0 expected 1");
        end else begin
            e.out = {8'h00, eo}; e.zr = ezr; e.ng = eng; e.cy = ecy; e.ov = eov;
            e.lat = lat; e.acc = cyc + 1;
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        x8 = 8'hA5; y8 = 8'h5A; mul8 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q16.size() != 0 || q8.size() != 0) && n < 60) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected16: got out 0x%0h expected no result", out16);
            end else begin
                e16 = q16.pop_front();
                chk("result16", {12'h0, out16, zr16, ng16, cy16, ov16},
                    {12'h0, e16.out, e16.zr, e16.ng, e16.cy, e16.ov});
                if (e16.lat >= 0) chk("latency16", cyc - e16.acc + 1, e16.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected8: got out 0x%0h expected no result", out8);
            end else begin
                e8 = q8.pop_front();
                chk("result8", {20'h0, out8, zr8, ng8, cy8, ov8},
                    {20'h0, e8.out[7:0], e8.zr, e8.ng, e8.cy, e8.ov});
                if (e8.lat >= 0) chk("latency8", cyc - e8.acc + 1, e8.lat);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid16", out_valid16, 0);
        chk("rst_in_ready16", in_ready16, 1);
        chk("rst_out16", {out16, zr16, ng16, cy16, ov16}, 0);
        chk("rst_out8", {out_valid8, in_ready8, out8, zr8, ng8, cy8, ov8}, 21'h40000 >> 6);
        @(posedge clk);
        #1;

        // 8-bit boundary cases
        issue8(8'h7F, 8'h01, 6'b000010, 1'b0, 8'h80, 0, 1, 0, 1, 1);
        issue8(8'hFF, 8'h01, 6'b000010, 1'b0, 8'h00, 1, 0, 1, 0, 1);
        issue8(8'd15, 8'd17, 6'b000000, 1'b1, 8'hFF, 0, 1, 0, 0, 9);

        // 16-bit Hack ops back to back, then multiplies
        issue16(16'd5, 16'd3, 6'b000010, 1'b0, 16'd8, 0, 0, 0, 0, 1, 1);
        issue16(16'd5, 16'd7, 6'b010011, 1'b0, 16'hFFFE, 0, 1, 1, 0, 1, 1);
        issue16(16'd9, 16'd9, 6'b010011, 1'b0, 16'h0000, 1, 0, 0, 0, 1, 1);
        issue16(16'h0F0F, 16'h00FF, 6'b000000, 1'b0, 16'h000F, 0, 0, 0, 0, 1, 1);
        issue16(16'h1234, 16'h5678, 6'b111010, 1'b0, 16'hFFFF, 0, 1, 0, 0, 1, 1);
        issue16(16'd7, 16'd6, 6'b000000, 1'b1, 16'd42, 0, 0, 0, 0, 17, 1);
        issue16(16'h0100, 16'h0100, 6'b000000, 1'b1, 16'h0000, 1, 0, 0, 0, 17, 1);
        issue16(16'd3, 16'd4, 6'b000011, 1'b1, 16'hFFF3, 0, 1, 0, 0, 17, 1);
        drain();

        // Hold result in DONE with out_ready low
        out_ready16 = 1'b0;
        issue16(16'd1, 16'd1, 6'b000010, 1'b0, 16'd2, 0, 0, 0, 0, -1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out16", {out_valid16, out16, zr16, ng16, cy16, ov16}, {1'b1, 16'd2, 4'b0000});
            chk("hold_in_ready16", in_ready16, 0);
        end
        @(posedge clk);
        #1;
        out_ready16 = 1'b1;
        issue16(16'd2, 16'd3, 6'b000010, 1'b0, 16'd5, 0, 0, 0, 0, 1, 1);
        drain();

        // Reset in the middle of a multiply
        issue16(16'd100, 16'd100, 6'b000000, 1'b1, 16'd0, 0, 0, 0, 0, -1, 0);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid16", out_valid16, 0);
        chk("midrst_out16", {out16, zr16, ng16, cy16, ov16}, 0);
        chk("midrst_in_ready16", in_ready16, 1);
        @(posedge clk);
        #1;
        issue16(16'd2, 16'd2, 6'b000010, 1'b0, 16'd4, 0, 0, 0, 0, 1, 1);
        repeat (25) @(negedge clk);
        drain();
        chk("drain16", q16.size(), 0);
        chk("drain8", q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
